fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Pipelined, parametrised IEEE-754-style floating-point adder/subtractor; successor to the
//  single-shot exponent-align/add block. Adds sign handling, normalisation, RNE rounding,
//  special values, status flags and a valid/ready stream interface.
//  Sits between operand source (register file / test driver) and result consumer.
//  Sustains one operation per clock.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MAN_W   23   stored mantissa width; hidden bit implicit; word width = 1+EXP_W+MAN_W
//  FTZ     1    1: subnormal inputs read as signed zero, subnormal results flushed to signed zero
// PORTS
//  clk         in   1                clock, all state on posedge
//  reset_n     in   1                reset, asynchronous assert, active-low
//  in_valid    in   1                operand pair valid
//  in_ready    out  1                block accepts operands this cycle
//  in_a        in   1+EXP_W+MAN_W    operand A
//  in_b        in   1+EXP_W+MAN_W    operand B
//  in_sub      in   1                1: A-B, 0: A+B
//  out_valid   out  1                result valid
//  out_ready   in   1                consumer accepts result
//  out_result  out  1+EXP_W+MAN_W    packed result
//  out_flags   out  4                {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset (reset_n=0): all stage valids=0, out_valid=0, out_result=0, out_flags=0; in_ready=1.
//    In-flight operations are discarded; no partial result after release.
//  - Handshake: transfer on valid&ready at each side. advance = !out_valid | out_ready;
//    in_ready = advance. All 3 stages shift together on advance, hold otherwise.
//    Bubbles propagate as valid=0. out_result/out_flags stable while out_valid&!out_ready.
//  - Latency: exactly 3 cycles accept->out_valid with no stall; throughput 1/clk.
//  - S1 unpack/align: eff. B sign = b_sign^in_sub; swap so |X|>=|Y| (compare exp, then mantissa);
//    hidden bit = (exp!=0); Y mantissa shifted right by exp diff into MAN_W+4 bits
//    (guard, round, sticky = OR of all bits shifted out); diff > MAN_W+3 -> Y becomes sticky only.
//  - S2 add: same sign -> add, else subtract (X>=Y, never negative); 1 carry bit kept.
//  - S3 normalise/round/pack: carry -> shift right 1, exp+1, fold into sticky; else left shift
//    by leading-zero count (bounded by exp-1). Round-to-nearest-even on G/R/S;
//    mantissa carry-out after rounding -> exp+1.
//  - Specials (exp all ones): NaN in -> canonical qNaN {0, all-ones exp, 1, 0...}.
//    inf-inf (eff. opposite signs) -> qNaN, invalid=1. inf op finite -> that inf, no flags.
//  - Zero result from cancellation: +0; (-0)+(-0) -> -0.
//  - Overflow: rounded exp >= all ones -> signed inf, overflow=1, inexact=1.
//  - Underflow (FTZ=1): normalised exp <= 0 -> signed zero, underflow=1, inexact=1.
//  - inexact = G|R|S nonzero before rounding, or flush/overflow.
//  - Flags belong to the result beside them; no sticky accumulation across ops.
// STRUCTURE
//  - Shared package fp_pkg: localparam helpers W = 1+EXP_W+MAN_W, EXP_MAX;
//    FLAG_INVALID/OVERFLOW/UNDERFLOW/INEXACT bit indices; canonical qNaN builder function;
//    stage payload typedefs.
//  - One sub-module: fp_lzc #(WIDTH) - combinational leading-zero count for S3 normalisation.
//  - Pipeline registers and handshake logic in fp_add_pipe.
// TESTING (defaults EXP_W=8, MAN_W=23)
//  1 32.0+5.0: a=0x42000000 b=0x40A00000 sub=0 -> 0x42140000, flags 0, out_valid 3 clk after accept
//  2 1.0-1.0: a=b=0x3F800000 sub=1 -> 0x00000000, flags 0; 0x80000000+0x80000000 -> 0x80000000
//  3 Rounding: 0x3F800000+0x33800000 (2^-24, tie) -> 0x3F800000 inexact=1;
//    0x3F800000+0x34400000 (3*2^-24) -> 0x3F800002 inexact=1
//  4 Specials: 0x7F800000-0x7F800000 -> 0x7FC00000 invalid=1;
//    0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 overflow=1 inexact=1
//  5 Backpressure: 20 back-to-back ops, out_ready=0 for cycles 4-9 -> in_ready drops,
//    all 20 results in order, none lost or duplicated
//  6 Reset mid-stream: reset_n low with 3 ops in flight -> out_valid=0 next cycle,
//    no stale results after release; next op correct at latency 3

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, helpers and payload types for the pipelined FP adder.
// Widths stay parameters of the adder, so the helpers take them as arguments.
package fp_pkg;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Special-operand class carried down the pipe alongside the datapath.
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF} special_e;

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: +, exponent all ones, MSB of the fraction set.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
  parameter  int WIDTH = 27,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    cnt
);

  // Scan LSB to MSB so the highest set bit is the one that sticks.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage IEEE-754-style add/sub: align, add, normalise/round/pack.
// Valid/ready stream; all stages advance together when the output can move.
module fp_add_pipe import fp_pkg::*; #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int FTZ   = 1,
  localparam int W     = word_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);

  localparam int MW   = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int SW   = MW + 1;     // plus carry
  localparam int XW   = EXP_W + 2;
  localparam int LCW  = $clog2(MW + 1);
  localparam int EMAX = exp_max(EXP_W);
  localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));

  typedef struct packed {
    logic             sx;
    logic             zsign;
    logic             eff_sub;
    logic [EXP_W-1:0] ex;
    logic [MW-1:0]    mx;
    logic [MW-1:0]    my;
    special_e         sp;
    logic             sp_sign;
    logic             inv;
  } s1_t;

  typedef struct packed {
    logic             sx;
    logic             zsign;
    logic [EXP_W-1:0] ex;
    logic [SW-1:0]    sum;
    special_e         sp;
    logic             sp_sign;
    logic             inv;
  } s2_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flags;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic [2:0] vld_d, vld_q;
  logic       advance;

  // ---------------- S1: unpack, order by magnitude, align ----------------
  logic             sa, sb, sy, swap, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] ea, eb, xa, xb, ey, diff;
  logic [MAN_W-1:0] fa, fb, fa_k, fb_k;
  logic [MAN_W:0]   ma, mb, mx_raw, my_raw;
  logic [MW-1:0]    y_ext, mask;

  always_comb begin
    sa   = in_a[W-1];
    sb   = in_b[W-1] ^ in_sub;
    ea   = in_a[W-2 -: EXP_W];
    eb   = in_b[W-2 -: EXP_W];
    fa   = in_a[MAN_W-1:0];
    fb   = in_b[MAN_W-1:0];
    fa_k = (FTZ != 0 && ea == '0) ? {MAN_W{1'b0}} : fa;
    fb_k = (FTZ != 0 && eb == '0) ? {MAN_W{1'b0}} : fb;
    // Subnormals live at exponent 1 without hidden bit; flushed ones at 0.
    xa   = (ea != '0) ? ea : ((FTZ != 0) ? {EXP_W{1'b0}} : EXP_W'(1));
    xb   = (eb != '0) ? eb : ((FTZ != 0) ? {EXP_W{1'b0}} : EXP_W'(1));
    ma   = {ea != '0, fa_k};
    mb   = {eb != '0, fb_k};
    swap = {xb, mb} > {xa, ma};

    s1_d       = '0;
    s1_d.sx    = swap ? sb : sa;
    sy         = swap ? sa : sb;
    s1_d.ex    = swap ? xb : xa;
    ey         = swap ? xa : xb;
    mx_raw     = swap ? mb : ma;
    my_raw     = swap ? ma : mb;
    s1_d.eff_sub = s1_d.sx ^ sy;
    s1_d.zsign = s1_d.sx & sy;
    s1_d.mx    = {mx_raw, 3'b000};

    diff  = s1_d.ex - ey;
    y_ext = {my_raw, 3'b000};
    mask  = (MW'(1) << diff) - MW'(1);
    if (int'(diff) > MW - 1)
      s1_d.my = {{(MW-1){1'b0}}, |my_raw};
    else
      s1_d.my = (y_ext >> diff) | MW'(|(y_ext & mask));

    a_nan = (ea == '1) && (fa != '0);
    b_nan = (eb == '1) && (fb != '0);
    a_inf = (ea == '1) && (fa == '0);
    b_inf = (eb == '1) && (fb == '0);
    if (a_nan || b_nan) begin
      s1_d.sp = SP_NAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      s1_d.sp  = SP_NAN;
      s1_d.inv = 1'b1;
    end else if (a_inf) begin
      s1_d.sp      = SP_INF;
      s1_d.sp_sign = sa;
    end else if (b_inf) begin
      s1_d.sp      = SP_INF;
      s1_d.sp_sign = sb;
    end
  end

  // ---------------- S2: magnitude add / subtract (X >= Y) ----------------
  always_comb begin
    s2_d.sx      = s1_q.sx;
    s2_d.zsign   = s1_q.zsign;
    s2_d.ex      = s1_q.ex;
    s2_d.sp      = s1_q.sp;
    s2_d.sp_sign = s1_q.sp_sign;
    s2_d.inv     = s1_q.inv;
    s2_d.sum     = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                                : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
  end

  // ---------------- S3: normalise, round to nearest even, pack ----------------
  logic [LCW-1:0]   lz;
  logic [MW-1:0]    m;
  logic [XW-1:0]    e, e_r, sh;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  logic             grs, rup, hid;

  fp_lzc #(.WIDTH(MW)) u_lzc (.din(s2_q.sum[MW-1:0]), .cnt(lz));

  always_comb begin
    sh = '0;
    if (s2_q.sum[SW-1]) begin
      m = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
      e = XW'(s2_q.ex) + XW'(1);
    end else begin
      // Left shift stops at exponent 1 so tiny results stay denormalised.
      if (s2_q.ex != '0)
        sh = (XW'(lz) < XW'(s2_q.ex)) ? XW'(lz) : XW'(s2_q.ex) - XW'(1);
      m = s2_q.sum[MW-1:0] << sh;
      e = XW'(s2_q.ex) - sh;
    end
    hid  = m[MW-1];
    grs  = |m[2:0];
    rup  = m[2] & (m[1] | m[0] | m[3]);
    mr   = {1'b0, m[MW-1:3]} + (MAN_W+2)'(rup);
    e_r  = e;
    frac = mr[MAN_W-1:0];
    if (mr[MAN_W+1]) begin
      frac = '0;
      e_r  = e + XW'(1);
    end

    s3_d = '0;
    if (s2_q.sp == SP_NAN) begin
      s3_d.res                 = QNAN;
      s3_d.flags[FLAG_INVALID] = s2_q.inv;
    end else if (s2_q.sp == SP_INF) begin
      s3_d.res = {s2_q.sp_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_q.sum == '0) begin
      s3_d.res = {s2_q.zsign, {(W-1){1'b0}}};
    end else if (FTZ != 0 && !hid) begin
      s3_d.res                   = {s2_q.sx, {(W-1){1'b0}}};
      s3_d.flags[FLAG_UNDERFLOW] = 1'b1;
      s3_d.flags[FLAG_INEXACT]   = 1'b1;
    end else if (e_r >= XW'(EMAX)) begin
      s3_d.res                  = {s2_q.sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      s3_d.flags[FLAG_OVERFLOW] = 1'b1;
      s3_d.flags[FLAG_INEXACT]  = 1'b1;
    end else begin
      s3_d.res = {s2_q.sx, (mr[MAN_W] | mr[MAN_W+1]) ? e_r[EXP_W-1:0] : {EXP_W{1'b0}}, frac};
      s3_d.flags[FLAG_UNDERFLOW] = !(mr[MAN_W] | mr[MAN_W+1]) & grs;
      s3_d.flags[FLAG_INEXACT]   = grs;
    end
  end

  // ---------------- Handshake and pipeline registers ----------------
  always_comb begin
    advance = !vld_q[2] | out_ready;
    vld_d   = advance ? {vld_q[1:0], in_valid} : vld_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (advance) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        s3_q <= s3_d;
      end
    end
  end

  assign in_ready   = advance;
  assign out_valid  = vld_q[2];
  assign out_result = s3_q.res;
  assign out_flags  = s3_q.flags;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed scoreboard bench for fp_add_pipe (EXP_W=8, MAN_W=23, FTZ=1).
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   popped = 0;
  int   stale = 0;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare whenever a result is presented (also while stalled).
  always @(negedge clk) begin
    if (reset_n && out_valid && (out_ready || sbq.size() != 0)) begin
      checks++;
      assert (sbq.size() != 0) else begin
        failures++;
        stale++;
        $error("FAIL unexpected_result got=%h expected=none", out_result);
      end
      if (sbq.size() != 0) begin
        chk("result", 64'(out_result), 64'(sbq[0].res));
        chk("flags", 64'(out_flags), 64'(sbq[0].flg));
        if (out_ready) begin
          void'(sbq.pop_front());
          popped++;
        end
      end
    end
  end

  function automatic logic [31:0] int_to_f32(input int n);
    int msb;
    msb = 0;
    for (int i = 0; i < 31; i++) if (n[i]) msb = i;
    return {1'b0, 8'(127 + msb), 23'(n << (23 - msb))};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] r, input logic [3:0] f, input bit push);
    in_a = a;
    in_b = b;
    in_sub = s;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    chk("accept", 64'(in_ready), 64'(1));
    if (push) sbq.push_back('{res: r, flg: f});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(sbq.size()), 64'(0));
  endtask

  task automatic latency_from_accept(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 64'(lat), 64'(3));
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_out_flags", 64'(out_flags), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    reset_n = 1'b1;
    @(negedge clk);

    // 32 + 5 with latency measurement
    send(32'h42000000, 32'h40A00000, 1'b0, 32'h42140000, 4'b0000, 1'b1);
    latency_from_accept("latency");
    drain();

    // Signed zeros, rounding, specials, flush, alignment boundaries
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 1'b1);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b1);
    send(32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'b0001, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b1);
    send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 1'b1);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1'b1);
    send(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 1'b1);
    send(32'h00800000, 32'h00400000, 1'b1, 32'h00800000, 4'b0000, 1'b1);
    send(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0001, 1'b1);
    send(32'h4F800000, 32'h3F800000, 1'b0, 32'h4F800000, 4'b0001, 1'b1);
    send(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 1'b1);
    drain();

    // 20 back-to-back ops with the consumer stalled for a window
    base = popped;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(int_to_f32(i + 10), int_to_f32(3), i[0],
               int_to_f32(i[0] ? i + 7 : i + 13), 4'b0000, 1'b1);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          @(posedge clk);
          #1;
          if (c == 4) out_ready = 1'b0;
          if (c == 7) chk("stall_in_ready", 64'(in_ready), 64'(0));
          if (c == 10) out_ready = 1'b1;
        end
      end
    join
    drain();
    chk("burst_count", 64'(popped - base), 64'(20));

    // Reset with the pipe full of unscored ops
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 4'b0, 1'b0);
    chk("full_out_valid", 64'(out_valid), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("rst_mid_out_valid_next", 64'(out_valid), 64'(0));
    chk("rst_mid_flags", 64'(out_flags), 64'(0));
    out_ready = 1'b1;
    reset_n = 1'b1;
    stale = 0;
    repeat (6) @(negedge clk);
    chk("no_stale", 64'(stale), 64'(0));
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b1);
    latency_from_accept("latency_after_reset");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
